// File: rtl/ram_ctrl_gen2.sv
// Core-to-block-RAM controller with a pending slot that waits on external busy; optional range check (RAM_CTRL_RANGE_CHECK_EN).
// Latency: read strobe T -> data/rbusy low at T+2+RD_LAT; write strobe T -> ram_wen T+1, wbusy low T+2 (busy=0).
// Backpressure: core is held via rbusy/wbusy; busy=1 parks an accepted request in PEND before any RAM strobe.
module ram_ctrl_gen2 #(
    parameter int          ADDR_W  = 10,
    parameter int          RD_LAT  = 1,
    parameter logic [31:0] IO_BASE = 32'h0000_0FFC,
    parameter logic [31:0] IO_MASK = 32'hFFFF_EFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       riscv_addr,
    input  logic [31:0]       riscv_wdata,
    input  logic [3:0]        riscv_wmask,
    input  logic              riscv_rstrb,
    output logic [31:0]       riscv_rdata,
    output logic              riscv_rbusy,
    output logic              riscv_wbusy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wen,
    output logic              ram_rden,
    output logic [3:0]        ram_byteena,
    input  logic [31:0]       ram_rdata,
    input  logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_ISSUE,
        S_RWAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t            r_state;
    logic              r_is_rd;
    logic              r_bad;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wmask;
    logic [1:0]        r_cnt;
    logic [31:0]       r_rdata;
    logic              r_rbusy;
    logic              r_wbusy;
    logic              r_ram_wen;
    logic              r_ram_rden;
    logic [3:0]        r_byteena;

    logic w_rd_req;
    logic w_wr_req;
    logic w_is_io;
    logic w_range_bad;
    logic w_accept;

    assign w_rd_req = riscv_rstrb;
    assign w_wr_req = !riscv_rstrb && (riscv_wmask != 4'b0000);
    assign w_is_io  = ((riscv_addr & IO_MASK) == (IO_BASE & IO_MASK));
    assign w_accept = (w_rd_req || w_wr_req) && !w_is_io &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef RAM_CTRL_RANGE_CHECK_EN
    logic r_err;

    assign w_range_bad = ((riscv_addr >> (ADDR_W + 2)) != 32'd0);
    assign err         = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_range_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_range_bad = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_is_rd    <= 1'b0;
            r_bad      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_rbusy    <= 1'b0;
            r_wbusy    <= 1'b0;
            r_ram_wen  <= 1'b0;
            r_ram_rden <= 1'b0;
            r_byteena  <= '0;
        end else begin
            // RAM strobes and byte enables are single-cycle pulses
            r_ram_wen  <= 1'b0;
            r_ram_rden <= 1'b0;
            r_byteena  <= '0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_is_rd <= w_rd_req;
                        r_bad   <= w_range_bad;
                        r_addr  <= riscv_addr[ADDR_W+1:2];
                        r_wdata <= riscv_wdata;
                        r_wmask <= riscv_wmask;
                        r_rbusy <= w_rd_req;
                        r_wbusy <= !w_rd_req;
                        // error accesses never touch the RAM, so busy cannot delay them
                        if (busy && !w_range_bad) begin
                            r_state <= S_PEND;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_ram_rden <= w_rd_req && !w_range_bad;
                            r_ram_wen  <= !w_rd_req && !w_range_bad;
                            r_byteena  <= (!w_rd_req && !w_range_bad) ? riscv_wmask : 4'b0000;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PEND: begin
                    if (!busy) begin
                        r_state    <= S_ISSUE;
                        r_ram_rden <= r_is_rd;
                        r_ram_wen  <= !r_is_rd;
                        r_byteena  <= r_is_rd ? 4'b0000 : r_wmask;
                    end
                end
                S_ISSUE: begin
                    if (!r_is_rd) begin
                        r_wbusy <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_bad) begin
                        r_rdata <= 32'hDEAD_BEEF;
                        r_rbusy <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    // the read is already in flight; busy no longer matters here
                    if (r_cnt == 2'd0) begin
                        r_rdata <= ram_rdata;
                        r_rbusy <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign riscv_rdata = r_rdata;
    assign riscv_rbusy = r_rbusy;
    assign riscv_wbusy = r_wbusy;
    assign ram_addr    = r_addr;
    assign ram_wdata   = r_wdata;
    assign ram_wen     = r_ram_wen;
    assign ram_rden    = r_ram_rden;
    assign ram_byteena = r_byteena;

endmodule

// File: doc/ram_ctrl_gen2.md
Name: ram_ctrl_gen2

Overview:
- Parametrised successor RAM controller between the RISC-V core (rstrb/wmask/rbusy/wbusy protocol) and a synchronous single-port block RAM.
- Generalises RAM depth, RAM read latency and the IO-window decode.
- Adds registered read data, a pending slot that stalls on external `busy` (PIM engine owning the RAM) and decoupled per-request byte enables.

Parameters:
- ADDR_W, 10, word-address width to RAM; depth = 2**ADDR_W words.
- RD_LAT, 1, RAM read latency in cycles (legal 1..3).
- IO_BASE, 32'h0000_0FFC, core byte address excluded from RAM (IO register).
- IO_MASK, 32'hFFFF_EFFF, address bits compared against IO_BASE (default also matches 0x1FFC).

Ports:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- riscv_addr  in  32  core byte address.
- riscv_wdata  in  32  core write data.
- riscv_wmask  in  4  core byte write mask; nonzero with rstrb=0 = write request.
- riscv_rstrb  in  1  core read strobe, one-cycle pulse.
- riscv_rdata  out  32  registered read data.
- riscv_rbusy  out  1  read in progress.
- riscv_wbusy  out  1  write in progress.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_wen  out  1  RAM write enable, one-cycle pulse.
- ram_rden  out  1  RAM read enable, one-cycle pulse.
- ram_byteena  out  4  RAM byte enables, valid with ram_wen.
- ram_rdata  in  32  RAM read data.
- busy  in  1  external RAM owner active; no RAM access may issue while high.
- err  out  1  sticky range-error flag (see Optional Feature).

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; pending slot cleared. Reset mid-operation aborts the request; no RAM strobe after reset asserts.
- Accept (IDLE only):
  - Read request: riscv_rstrb=1.
  - Write request: riscv_rstrb=0 and riscv_wmask!=0.
  - rstrb has priority when both are present.
  - An IO-window access ((riscv_addr & IO_MASK)==(IO_BASE & IO_MASK)) is not accepted; no busy and no RAM strobe; riscv_rdata keeps its value.
- Capture on accept: addr[ADDR_W+1:2], wdata and wmask are registered. Later core input changes are ignored until return to IDLE.
- States: IDLE, PEND, ISSUE, RWAIT, DONE.
  - IDLE -> ISSUE on accept with busy=0; IDLE -> PEND on accept with busy=1.
  - PEND -> ISSUE when busy=0. PEND holds with no RAM strobes and the core busy flag high.
  - ISSUE: ram_rden or ram_wen high for exactly this cycle; ram_addr, ram_wdata and ram_byteena driven from the capture registers.
  - ISSUE(write) -> IDLE; ISSUE(read) -> RWAIT.
  - RWAIT counts RD_LAT cycles. In the last of these, ram_rdata is registered into riscv_rdata; then -> DONE.
  - DONE: rbusy=0, riscv_rdata valid; -> IDLE next cycle. A new accept is allowed in DONE.
- Busy flags:
  - rbusy is registered: high from the cycle after rstrb until DONE.
  - wbusy is registered: high from the cycle after the write request through ISSUE.
  - Flags are never both high.
- Latency with busy=0:
  - Read: strobe at T, riscv_rdata valid and rbusy low at T+2+RD_LAT.
  - Write: strobe at T, ram_wen at T+1, wbusy low at T+2.
- `busy` rising during RWAIT does not abort the read. The RAM read already issued; data is still captured.
- Core strobes while not IDLE/DONE are ignored (protocol violation, no state change).
- ram_byteena is 0 outside write ISSUE; ram_rden and ram_wen are never both high.

Optional Feature:
- Macro: RAM_CTRL_RANGE_CHECK_EN.
- With the macro:
  - Any accepted access with riscv_addr[31:ADDR_W+2]!=0 that is not an IO-window access is an error access.
  - An error access issues no RAM strobe and completes in 1 busy cycle.
  - An error read returns 32'hDEAD_BEEF.
  - err is set and stays set until reset.
- Without the macro: upper address bits are ignored (aliasing), and err is tied 0.

Test Plan:
- Write 0xCAFEF00D, wmask 4'b1111, addr 0x010, busy=0 -> ram_wen=1 at T+1 with ram_addr=4 and ram_byteena=4'hF; wbusy high 1 cycle.
- Read addr 0x010 with RD_LAT=1 and RD_LAT=3 -> riscv_rdata=0xCAFEF00D and rbusy low at T+3 and T+5 respectively.
- Byte write wmask 4'b0100, wdata 0x00AB0000, then read -> ram_byteena=4'b0100; read returns 0xCAAB F00D (0xCAABF00D).
- Hold busy=1 for 5 cycles across a read strobe -> no ram_rden while busy; ram_rden 1 cycle after busy falls; rbusy high throughout.
- Access 0xFFC and 0x1FFC (read and write) -> no rbusy, wbusy, ram_rden or ram_wen; riscv_rdata unchanged.
- Assert reset_n low during RWAIT, and with the macro read 0x4000 (ADDR_W=10) -> after reset all outputs 0 and IDLE; range-error read returns 0xDEADBEEF, err=1 sticky, no RAM strobe.
